if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset: sampled on rising clk; low = reset.
REQ-004 we  in  1  ID accepts a new instruction this cycle; 0 = stall, from hazard unit.
REQ-005 flush  in  1  squash the IF/ID output register.
REQ-006 redirect  in  1  taken jump/branch/exception; highest priority.
REQ-007 redirect_pc  in  32  new fetch address when redirect=1.
REQ-008 imem_req  out  1  fetch request; held with imem_addr stable until imem_ack.
REQ-009 imem_addr  out  32  word address being fetched; always equals PC register.
REQ-010 imem_ack  in  1  response valid; may arrive in the cycle of imem_req or later.
REQ-011 imem_rdata  in  32  instruction word, valid only with imem_ack.
REQ-012 instruction  out  32  registered instruction to ID; 32'h0 (NOP) when invalid.
REQ-013 pc_next  out  32  registered fetch address + 4 of that instruction.
REQ-014 if_valid  out  1  instruction/pc_next hold a real fetched instruction.

Function
REQ-015 States: FETCH (request outstanding), HOLD (word buffered, ID stalled), DRAIN (stale request pending after redirect).
REQ-016 FETCH: imem_req=1; on imem_ack with we=1, output register <= {imem_rdata, PC+4, valid=1}, PC <= PC+4, stay FETCH (1 instr/cycle with same-cycle ack).
REQ-017 FETCH, imem_ack with we=0: word and PC+4 into one-entry buffer, PC <= PC+4, go HOLD; output register unchanged.
REQ-018 FETCH, no ack, we=1: output register <= NOP, pc_next unchanged, valid=0 (bubble).
REQ-019 HOLD: imem_req=0; on we=1 output register <= buffer, go FETCH.
REQ-020 redirect=1 in FETCH with ack or no request outstanding (FETCH, ack same cycle): response dropped, PC <= redirect_pc, stay FETCH.
REQ-021 redirect=1 in FETCH without ack: PC shadowed, go DRAIN; imem_addr held at old address until ack; on ack response discarded, imem_addr <= redirect_pc, go FETCH.
REQ-022 redirect=1 in HOLD: buffer discarded, PC <= redirect_pc, go FETCH.
REQ-023 redirect=1 in DRAIN: redirect target overwritten with newest redirect_pc.
REQ-024 Any redirect cycle with we=1 loads output register with NOP, valid=0.
REQ-025 flush=1: output register <= NOP, pc_next=0, valid=0, regardless of we; PC/state unaffected except redirect rules.
REQ-026 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.

Reset
REQ-027 reset=0: PC=RESET_PC, state FETCH, buffer empty, instruction=0, pc_next=0, if_valid=0; imem_req=1 from first cycle after reset deasserts.
REQ-028 reset mid-DRAIN/HOLD: state discarded; a late imem_ack from pre-reset request is ignored in the first post-reset cycle only if it arrives in that cycle.

Configuration
REQ-029 IF_ALIGN_EXC_EN defined: output exc_adel (1 bit, registered with instruction) set when PC[1:0]!=0; no imem_req issued for misaligned PC, output NOP with exc_adel=1, valid=1; PC holds until redirect.
REQ-030 IF_ALIGN_EXC_EN undefined: no exc_adel port; PC[1:0] forced to 0 on imem_addr.

Structure
REQ-031 Package if_pkg: state enum (FETCH, HOLD, DRAIN), NOP constant 32'h0, default RESET_PC.
REQ-032 One sub-module: fetch_buffer (one-entry instruction+pc_next holding register with load/clear).

Verification
REQ-033 Reset release, ack every cycle, rdata=PC: imem_addr BFC0_0000, 0004, 0008; instruction follows one cycle later, pc_next=addr+4.
REQ-034 we=0 on ack of BFC0_0004 for 3 cycles: imem_req=0 in HOLD, instruction then 0004 word, no fetch lost or duplicated.
REQ-035 Ack latency 2, redirect to 0000_0100 one cycle after req: old word discarded, next imem_addr 0000_0100, if_valid=0 during drain.
REQ-036 flush=1 with valid instruction: instruction=0, if_valid=0 next cycle, PC continues.
REQ-037 PC=FFFF_FFFC, ack: pc_next=0000_0000, next imem_addr 0000_0000.
REQ-038 IF_ALIGN_EXC_EN, redirect_pc=0000_0102: imem_req=0, exc_adel=1, instruction=0.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch stage
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/if_stage_fetch_buffer.sv
// rtl/if_stage_fetch_buffer.sv - one-entry instruction/pc_next holding register
module fetch_buffer
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc_next,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc_next,
  output logic        q_valid
);

  // capture a fetched word while ID is stalled; clear wins over load
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_instr   <= NOP;
      q_pc_next <= 32'h0;
      q_valid   <= 1'b0;
    end else if (clear) begin
      q_instr   <= NOP;
      q_pc_next <= 32'h0;
      q_valid   <= 1'b0;
    end else if (load) begin
      q_instr   <= d_instr;
      q_pc_next <= d_pc_next;
      q_valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage: PC, imem handshake, IF/ID register (option macro IF_ALIGN_EXC_EN)
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_next,
`ifdef IF_ALIGN_EXC_EN
  output logic        exc_adel,
`endif
  output logic        if_valid
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic        first_cycle;
  logic        misaligned;
  logic        req_active;
  logic        ack_ok;
  logic        buf_load;
  logic        buf_clear;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc_next;
  logic        out_load;
  logic [31:0] out_instr_d;
  logic [31:0] out_pc_next_d;
  logic        out_valid_d;

`ifdef IF_ALIGN_EXC_EN
  localparam logic [31:0] START_PC = RESET_PC;
  assign misaligned   = (pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;
  assign imem_addr    = pc;
`else
  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;
  assign misaligned   = 1'b0;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr    = pc & 32'hFFFF_FFFC;
`endif

  assign pc_plus4   = imem_addr + 32'd4;
  assign req_active = (state == DRAIN) || ((state == FETCH) && !misaligned);
  assign imem_req   = req_active;
  // an ack landing in the first cycle after reset belongs to a pre-reset request
  assign ack_ok     = imem_ack && req_active && !first_cycle;
  assign buf_load   = (state == FETCH) && ack_ok && !we && !redirect;
  assign buf_clear  = (state == HOLD) && (we || redirect);
  assign out_load   = flush || we;

  fetch_buffer u_fetch_buffer (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .clear     (buf_clear),
    .d_instr   (imem_rdata),
    .d_pc_next (pc_plus4),
    .q_instr   (buf_instr),
    .q_pc_next (buf_pc_next),
    .q_valid   (buf_valid)
  );

  // PC, drain target and fetch state sequencing
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= START_PC;
      target      <= START_PC;
      first_cycle <= 1'b1;
    end else begin
      first_cycle <= 1'b0;
      case (state)
        FETCH: begin
          if (redirect) begin
            if (ack_ok || !req_active) begin
              pc <= redirect_tgt;
            end else begin
              target <= redirect_tgt;
              state  <= DRAIN;
            end
          end else if (ack_ok) begin
            pc <= pc_plus4;
            if (!we) state <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= redirect_tgt;
            state <= FETCH;
          end else if (we) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect) target <= redirect_tgt;
          if (ack_ok) begin
            pc    <= redirect ? redirect_tgt : target;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // next IF/ID contents: flush and redirect squash, otherwise source by state
  always_comb begin
    out_instr_d   = NOP;
    out_pc_next_d = pc_next;
    out_valid_d   = 1'b0;
    if (flush) begin
      out_pc_next_d = 32'h0;
    end else if (!redirect) begin
      case (state)
        FETCH: begin
          if (misaligned) begin
            out_pc_next_d = pc_plus4;
            out_valid_d   = 1'b1;
          end else if (ack_ok) begin
            out_instr_d   = imem_rdata;
            out_pc_next_d = pc_plus4;
            out_valid_d   = 1'b1;
          end
        end
        HOLD: begin
          out_instr_d   = buf_instr;
          out_pc_next_d = buf_pc_next;
          out_valid_d   = buf_valid;
        end
        default: ;
      endcase
    end
  end

  // IF/ID output register, advanced only when ID accepts or on flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      instruction <= NOP;
      pc_next     <= 32'h0;
      if_valid    <= 1'b0;
    end else if (out_load) begin
      instruction <= out_instr_d;
      pc_next     <= out_pc_next_d;
      if_valid    <= out_valid_d;
    end
  end

`ifdef IF_ALIGN_EXC_EN
  // address-error flag travels with the NOP issued for a misaligned PC
  always_ff @(posedge clk) begin
    if (!reset) begin
      exc_adel <= 1'b0;
    end else if (out_load) begin
      exc_adel <= !flush && !redirect && (state == FETCH) && misaligned;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage: directed steps then randomized fetch stream
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_next;
  logic        if_valid;
`ifdef IF_ALIGN_EXC_EN
  logic        exc_adel;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pcn;
  logic [31:0] last_addr;
  logic [31:0] p_target;
  logic        p_we;
  logic        p_flush;
  logic        p_redir;
  logic        p_req;
  logic        p_ack;
  logic        r_ack;
  logic        r_we;
  logic        r_redir;
  logic        r_flush;
  logic [31:0] r_pc;
  int          busy;
  int          wait_left;
  int          loads;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_next     (pc_next),
`ifdef IF_ALIGN_EXC_EN
    .exc_adel    (exc_adel),
`endif
    .if_valid    (if_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic f, input logic r, input logic [31:0] rp,
                       input logic a, input logic [31:0] rd);
    we = w; flush = f; redirect = r; redirect_pc = rp; imem_ack = a; imem_rdata = rd;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); step(); step();
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'hBFC0_0000);

    reset = 1'b1;
    step();
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, 32'hBFC0_0000);
    chk("post_rst_valid", 32'(if_valid), 32'd0);

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, imem_addr); step();
    chk("seq0_addr", imem_addr, 32'hBFC0_0004);
    chk("seq0_instr", instruction, 32'hBFC0_0000);
    chk("seq0_pcn", pc_next, 32'hBFC0_0004);
    chk("seq0_valid", 32'(if_valid), 32'd1);

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, imem_addr); step();
    chk("hold_req0", 32'(imem_req), 32'd0);
    chk("hold_addr", imem_addr, 32'hBFC0_0008);
    chk("hold_instr", instruction, 32'hBFC0_0000);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_0000);
      step();
      chk("hold_req", 32'(imem_req), 32'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0); step();
    chk("unhold_instr", instruction, 32'hBFC0_0004);
    chk("unhold_pcn", pc_next, 32'hBFC0_0008);
    chk("unhold_valid", 32'(if_valid), 32'd1);
    chk("unhold_req", 32'(imem_req), 32'd1);
    chk("unhold_addr", imem_addr, 32'hBFC0_0008);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, imem_addr); step();
    chk("seq2_instr", instruction, 32'hBFC0_0008);
    chk("seq2_pcn", pc_next, 32'hBFC0_000C);
    chk("seq2_addr", imem_addr, 32'hBFC0_000C);

    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, imem_addr); step();
    chk("flush_instr", instruction, 32'h0);
    chk("flush_valid", 32'(if_valid), 32'd0);
    chk("flush_pcn", pc_next, 32'h0);
    chk("flush_addr", imem_addr, 32'hBFC0_0010);

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0); step();
    chk("bubble_valid", 32'(if_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0); step();
    chk("drain_addr", imem_addr, 32'hBFC0_0010);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_valid", 32'(if_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF); step();
    chk("drain_done_addr", imem_addr, 32'h0000_0100);
    chk("drain_done_valid", 32'(if_valid), 32'd0);
    chk("drain_done_instr", instruction, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, imem_addr); step();
    chk("tgt_instr", instruction, 32'h0000_0100);
    chk("tgt_pcn", pc_next, 32'h0000_0104);
    chk("tgt_valid", 32'(if_valid), 32'd1);

    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, imem_addr); step();
    chk("redir_ack_addr", imem_addr, 32'hFFFF_FFFC);
    chk("redir_ack_valid", 32'(if_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, imem_addr); step();
    chk("wrap_instr", instruction, 32'hFFFF_FFFC);
    chk("wrap_pcn", pc_next, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, imem_addr); step();
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0); step();
    chk("hold_redir_addr", imem_addr, 32'h0000_0200);
    chk("hold_redir_req", 32'(imem_req), 32'd1);
    chk("hold_redir_instr", instruction, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, imem_addr); step();
    chk("hold_redir_next", instruction, 32'h0000_0200);
    chk("hold_redir_pcn", pc_next, 32'h0000_0204);

`ifdef IF_ALIGN_EXC_EN
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b1, imem_addr); step();
    chk("adel_req", 32'(imem_req), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0); step();
    chk("adel_flag", 32'(exc_adel), 32'd1);
    chk("adel_instr", instruction, 32'h0);
    chk("adel_valid", 32'(if_valid), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0); step();
    chk("adel_clear", 32'(exc_adel), 32'd0);
`endif

    drive(1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0); step();
    chk("pre_rst_drain_addr", imem_addr, 32'h0000_0204);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0); step();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0); step();
    chk("late_ack_addr", imem_addr, 32'hBFC0_0000);
    chk("late_ack_valid", 32'(if_valid), 32'd0);
    chk("late_ack_req", 32'(imem_req), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, imem_addr); step();
    chk("rst2_instr", instruction, 32'hBFC0_0000);
    chk("rst2_pcn", pc_next, 32'hBFC0_0004);
    chk("rst2_addr", imem_addr, 32'hBFC0_0004);

    exp_pcn = 32'hBFC0_0008;
    p_we = 1'b0; p_flush = 1'b0; p_redir = 1'b0; p_req = 1'b0; p_ack = 1'b0;
    p_target = 32'h0; last_addr = 32'h0;
    busy = 0; wait_left = 0; loads = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (p_flush) begin
        chk("rnd_flush_instr", instruction, 32'h0);
        chk("rnd_flush_valid", 32'(if_valid), 32'd0);
        chk("rnd_flush_pcn", pc_next, 32'h0);
      end else if (p_we && p_redir) begin
        chk("rnd_redir_valid", 32'(if_valid), 32'd0);
        chk("rnd_redir_instr", instruction, 32'h0);
      end else if (p_we) begin
        if (if_valid) begin
          loads++;
          chk("rnd_pcn", pc_next, exp_pcn);
          chk("rnd_instr", instruction, mem_word(exp_pcn - 32'd4));
          exp_pcn = exp_pcn + 32'd4;
        end else begin
          chk("rnd_bubble", instruction, 32'h0);
        end
      end
      if (p_redir) exp_pcn = p_target + 32'd4;
      if (p_req && !p_ack) begin
        chk("rnd_req_held", 32'(imem_req), 32'd1);
        chk("rnd_addr_held", imem_addr, last_addr);
      end

      if (p_ack) busy = 0;
      else if (busy != 0 && wait_left > 0) wait_left--;
      if (imem_req && busy == 0) begin
        busy = 1;
        wait_left = $urandom_range(0, 2);
      end
      r_ack   = imem_req && (busy != 0) && (wait_left == 0);
      r_we    = ($urandom_range(0, 3) != 0);
      r_redir = ($urandom_range(0, 11) == 0);
      r_flush = r_redir && ($urandom_range(0, 1) == 1);
      r_pc    = $urandom & 32'hFFFF_FFFC;
      drive(r_we, r_flush, r_redir, r_pc, r_ack, r_ack ? mem_word(imem_addr) : $urandom);

      p_we = r_we; p_flush = r_flush; p_redir = r_redir; p_target = r_pc;
      p_req = imem_req; p_ack = r_ack; last_addr = imem_addr;
      step();
    end
    chk("rnd_progress", 32'(loads > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
